// File: rtl/out_streamer_if.sv
// Handshake bundle between out_streamer and its environment: the start/config inputs,
// the OUT_MEM read port, and the row-major element stream with status pulses.
interface out_streamer_if #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int AW    = 4
);
    logic                    start;
    logic [11:0]             mnt;
    logic                    en_o;
    logic [AW-1:0]           addr_o;
    logic [DW*LANES-1:0]     rdata_o;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [DW-1:0]    out_data;
    logic [2:0]              out_row;
    logic [2:0]              out_col;
    logic                    out_last;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        input  start, mnt, rdata_o, out_ready,
        output en_o, addr_o, out_valid, out_data, out_row, out_col, out_last, busy, done, err
    );

    modport slave (
        output start, mnt, rdata_o, out_ready,
        input  en_o, addr_o, out_valid, out_data, out_row, out_col, out_last, busy, done, err
    );
endinterface

// File: rtl/out_streamer.sv
// Drains the T x M result tile from OUT_MEM after a matrix multiply and emits it row-major,
// one element per valid/ready handshake, tagged with its row/column.
module out_streamer #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int AW    = 4,
    parameter int MAXD  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    out_streamer_if.master bus
);
    localparam int WW = DW * LANES;
    localparam logic [3:0]    MAXD4   = 4'(MAXD);
    // Columns 4..7 of row t live in the upper half of the memory, at MAXD + t.
    localparam logic [AW-1:0] HI_BASE = AW'(MAXD);

    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WAIT, ST_EMIT, ST_DONE} state_t;

    state_t          state;
    logic [3:0]      m_lat;
    logic [3:0]      t_lat;
    logic [2:0]      row;
    logic            half;
    logic [1:0]      lane;
    logic [WW-1:0]   word_buf;

    function automatic logic signed [DW-1:0] lane_sel(input logic [WW-1:0] w, input logic [1:0] l);
        lane_sel = w[(LANES - 1 - int'(l)) * DW +: DW];
    endfunction

    logic [3:0] m_in, t_in;
    logic       legal;
    logic       n_unused;
    assign m_in     = bus.mnt[11:8];
    assign t_in     = bus.mnt[3:0];
    assign n_unused = ^bus.mnt[7:4];  // N is carried in MNT but irrelevant to draining
    assign legal    = (m_in != 4'd0) && (m_in <= MAXD4) && (t_in != 4'd0) && (t_in <= MAXD4);

    logic [3:0]    n_lanes;
    logic          last_lane, nx_lane_last, last_word, hs;
    logic          nx_half;
    logic [2:0]    nx_row;
    logic [AW-1:0] nx_addr;

    always_comb begin
        n_lanes      = half ? (m_lat - 4'd4) : ((m_lat > 4'd4) ? 4'd4 : m_lat);
        last_lane    = ({2'b00, lane} == n_lanes - 4'd1);
        nx_lane_last = ({2'b00, lane} + 4'd2 == n_lanes);
        last_word    = ({1'b0, row} == t_lat - 4'd1) && (half || (m_lat <= 4'd4));
        hs           = bus.out_valid && bus.out_ready;
        if (!half && (m_lat > 4'd4)) begin
            nx_half = 1'b1;
            nx_row  = row;
        end else begin
            nx_half = 1'b0;
            nx_row  = row + 3'd1;
        end
        nx_addr = (nx_half ? HI_BASE : '0) + AW'(nx_row);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            m_lat         <= '0;
            t_lat         <= '0;
            row           <= '0;
            half          <= 1'b0;
            lane          <= '0;
            word_buf      <= '0;
            bus.en_o      <= 1'b0;
            bus.addr_o    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                    if (bus.start) begin
                        m_lat    <= m_in;
                        t_lat    <= t_in;
                        bus.busy <= 1'b1;
                        if (legal) begin
                            state      <= ST_RD;
                            bus.en_o   <= 1'b1;
                            bus.addr_o <= '0;
                            row        <= '0;
                            half       <= 1'b0;
                            lane       <= '0;
                        end else begin
                            state    <= ST_DONE;
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    bus.en_o <= 1'b0;
                    state    <= ST_WAIT;
                end
                // Read data is present this cycle; present lane 0 straight away.
                ST_WAIT: begin
                    word_buf      <= bus.rdata_o;
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= lane_sel(bus.rdata_o, 2'd0);
                    bus.out_row   <= row;
                    bus.out_col   <= {half, 2'b00};
                    bus.out_last  <= last_word && last_lane;
                    state         <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (hs) begin
                        if (last_lane) begin
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            if (last_word) begin
                                state    <= ST_DONE;
                                bus.done <= 1'b1;
                            end else begin
                                state      <= ST_RD;
                                bus.en_o   <= 1'b1;
                                bus.addr_o <= nx_addr;
                                row        <= nx_row;
                                half       <= nx_half;
                                lane       <= '0;
                            end
                        end else begin
                            lane         <= lane + 2'd1;
                            bus.out_data <= lane_sel(word_buf, lane + 2'd1);
                            bus.out_col  <= {half, lane + 2'd1};
                            bus.out_last <= last_word && nx_lane_last;
                        end
                    end
                end
                ST_DONE: begin
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_out_streamer.sv
// Bench for out_streamer: table of drain configurations plus random ones, each checked
// against a row-major model of the tile built directly from the memory contents.
module tb_out_streamer;
    localparam int DW = 16, LANES = 4, AW = 4, MAXD = 8;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        last;
    } elem_t;

    typedef struct {
        logic [11:0] mnt;
        int          rmode;
        bit          mid;
        int          exp_busy;
        int          exp_n;
        int          exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    out_streamer_if #(.DW(DW), .LANES(LANES), .AW(AW)) bus ();
    out_streamer #(.DW(DW), .LANES(LANES), .AW(AW), .MAXD(MAXD)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [63:0] mem [16];
    always @(posedge clk) if (bus.en_o) bus.rdata_o <= mem[bus.addr_o];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rdy_mode = 0;
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples on the falling edge, records reads, transfers and status.
    int    run_id = 0, seen_id = 0;
    int    rd_q[$];
    elem_t got_q[$];
    elem_t cur, prev_e;
    logic  prev_stall;
    int    fv_cyc, fe_cyc, last_cyc, done_cyc, done_cnt, busy_cnt, stall_viol, err_stray;
    logic  done_err;

    always @(negedge clk) begin
        if (run_id != seen_id) begin
            seen_id = run_id;
            rd_q.delete();
            got_q.delete();
            fv_cyc = -1; fe_cyc = -1; last_cyc = -1; done_cyc = -1;
            done_cnt = 0; busy_cnt = 0; stall_viol = 0; err_stray = 0;
            done_err = 1'b0; prev_stall = 1'b0;
        end
        cur = {bus.out_data, bus.out_row, bus.out_col, bus.out_last};
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (bus.en_o) begin
                rd_q.push_back(int'(bus.addr_o));
                if (fe_cyc < 0) fe_cyc = cyc;
            end
            if (bus.out_valid && fv_cyc < 0) fv_cyc = cyc;
            if (prev_stall && (!bus.out_valid || cur != prev_e)) stall_viol++;
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(cur);
                if (bus.out_last) last_cyc = cyc;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_e     = cur;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = bus.err;
            end else if (bus.err) err_stray++;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    endtask

    function automatic logic [63:0] outs_now();
        return {bus.en_o, bus.addr_o, bus.out_valid, bus.out_data, bus.out_row,
                bus.out_col, bus.out_last, bus.busy, bus.done, bus.err};
    endfunction

    task automatic run_case(input logic [11:0] mnt, input int rmode, input bit mid,
                            input int exp_busy, input int exp_n, input int exp_err);
        int    m, t, k, a;
        bit    bad;
        int    exp_rd[$];
        elem_t exp_q[$];
        logic [63:0] w;
        m   = int'(mnt[11:8]);
        t   = int'(mnt[3:0]);
        bad = (m == 0) || (m > MAXD) || (t == 0) || (t > MAXD);
        // Reference tile: element (t,m) sits in lane m%4 of word (m>=4 ? 8 : 0) + t.
        if (!bad) begin
            for (int r = 0; r < t; r++) begin
                exp_rd.push_back(r);
                if (m > 4) exp_rd.push_back(8 + r);
                for (int c = 0; c < m; c++) begin
                    a = (c >= 4 ? 8 : 0) + r;
                    w = mem[a] >> (16 * (3 - (c % 4)));
                    exp_q.push_back({w[15:0], 3'(r), 3'(c), (r == t - 1) && (c == m - 1)});
                end
            end
        end
        rdy_mode = rmode;
        run_id++;
        tick();
        k = cyc;
        bus.mnt   = mnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (mid) begin
            repeat (4) tick();
            bus.mnt   = 12'h222;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
        repeat (3) tick();

        check("done_count", done_cnt, 1);
        check("err_flag", done_err, bad);
        check("err_without_done", err_stray, 0);
        check("busy_span", busy_cnt, done_cyc - k);
        check("stall_hold", stall_viol, 0);
        if (bad) begin
            check("err_done_cycle", done_cyc, k + 1);
            check("err_no_valid", fv_cyc, -1);
        end else begin
            check("first_en_cycle", fe_cyc, k + 1);
            check("first_valid_cycle", fv_cyc, k + 3);
            check("done_after_last", done_cyc, last_cyc + 1);
        end
        check("n_reads", rd_q.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
            check($sformatf("read_addr[%0d]", i), rd_q[i], exp_rd[i]);
        check("n_elems", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("elem[%0d]", i), got_q[i], exp_q[i]);
        if (exp_busy >= 0) check("tbl_busy", busy_cnt, exp_busy);
        if (exp_n >= 0)    check("tbl_elems", got_q.size(), exp_n);
        if (exp_err >= 0)  check("tbl_err", done_err, exp_err);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{12'h444, 1, 1'b0, 25, 16, 0};
        vecs[1] = '{12'h644, 1, 1'b0, 41, 24, 0};
        vecs[2] = '{12'h444, 2, 1'b0, -1, 16, 0};
        vecs[3] = '{12'h888, 1, 1'b0, 97, 64, 0};
        vecs[4] = '{12'h044, 1, 1'b0, 1, 0, 1};
        vecs[5] = '{12'h449, 1, 1'b0, 1, 0, 1};
        vecs[6] = '{12'h644, 1, 1'b1, 41, 24, 0};

        bus.start = 1'b0;
        bus.mnt   = 12'h000;
        fill_mem();
        repeat (3) tick();
        check("reset_outputs", outs_now(), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_outputs", outs_now(), 64'd0);

        for (int v = 0; v < 7; v++) begin
            fill_mem();
            run_case(vecs[v].mnt, vecs[v].rmode, vecs[v].mid,
                     vecs[v].exp_busy, vecs[v].exp_n, vecs[v].exp_err);
        end

        // Abort while an element is waiting for the consumer.
        fill_mem();
        rdy_mode = 0;
        run_id++;
        tick();
        bus.mnt   = 12'h444;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        check("reach_emit", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", outs_now(), 64'd0);
        repeat (3) tick();
        check("abort_no_done", done_cnt, 0);
        rst_n = 1'b1;
        tick();
        fill_mem();
        run_case(12'h444, 1, 1'b0, 25, 16, 0);

        for (int r = 0; r < 8; r++) begin
            logic [11:0] mnt;
            mnt = {4'($urandom_range(0, 9)), 4'($urandom), 4'($urandom_range(0, 9))};
            fill_mem();
            run_case(mnt, $urandom_range(1, 2), 1'b0, -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
